// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Types and constants shared by the cache and the block memory responder.
//   INSTR_TYPE   : operation latched with a block request (READ / WRITE)
//   resp_state_t : responder handshake states
//   BL_NUM_BYTES : bytes per block; BL_OFFSET_W is the byte-offset width
//                  stripped from a byte address to form a block index
// ---------------------------------------------------------------------------
package mem_if_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } INSTR_TYPE;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        LOAD_DONE,
        STORE_DONE,
        ACK_LOW
    } resp_state_t;

    localparam int BL_NUM_BYTES = 4;
    localparam int BL_OFFSET_W  = $clog2(BL_NUM_BYTES);

endpackage

// File: rtl/block_mem_array.sv
// ---------------------------------------------------------------------------
// block_mem_array
// Single-port synchronous block array. Contents are never cleared; the read
// port is registered and returns the word stored before any same-edge write.
// Ports:
//   i_clk   : clock
//   i_we    : write enable
//   i_addr  : block index
//   i_wdata : block to write
//   o_rdata : block read at i_addr on the previous edge
// ---------------------------------------------------------------------------
module block_mem_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int BLOCK_W    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [BLOCK_W-1:0]    i_wdata,
    output logic [BLOCK_W-1:0]    o_rdata
);

    logic [BLOCK_W-1:0] r_mem [2**DEPTH_LOG2];

    // Storage plus registered read. There is deliberately no reset here so
    // the contents survive a responder reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/block_mem_responder.sv
// ---------------------------------------------------------------------------
// block_mem_responder
// Memory-side responder for the cache block load/store handshake. Accepts one
// block request at a time, services it from block_mem_array after LATENCY
// edges and holds the completion flag until the cache hands it back.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   address_in      : byte address; block index = address_in[DEPTH_LOG2+1:2]
//   data_in         : block to store
//   load_req        : cache requests a block load
//   store_req       : cache requests a block store (wins over load_req)
//   store_ack       : cache acknowledges store_completed
//   data_out        : loaded block, valid while load_completed is high
//   load_completed  : load data valid
//   store_completed : block written
//   addr_err        : only with MEM_RESP_ERR_EN; misaligned or out-of-range
//                     address, raised and cleared together with completion
//   busy            : high whenever the responder is not IDLE
// Optional feature macro: MEM_RESP_ERR_EN
// ---------------------------------------------------------------------------
module block_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int BLOCK_W    = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_in,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               load_req,
    input  logic               store_req,
    input  logic               store_ack,
    output logic [BLOCK_W-1:0] data_out,
    output logic               load_completed,
    output logic               store_completed,
`ifdef MEM_RESP_ERR_EN
    output logic               addr_err,
`endif
    output logic               busy
);

    localparam int IDX_HI = DEPTH_LOG2 + BL_OFFSET_W - 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    resp_state_t           r_state;
    INSTR_TYPE             r_op;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [BLOCK_W-1:0]    r_wdata;
    logic [CNT_W-1:0]      r_latCount;
    logic                  r_err;

    logic [DEPTH_LOG2-1:0] w_reqIndex;
    logic                  w_reqErr;
    logic                  w_lastCycle;
    logic                  w_arrWe;
    logic [DEPTH_LOG2-1:0] w_arrAddr;
    logic [BLOCK_W-1:0]    w_arrRdata;

    // Upper address bits beyond the index simply wrap the block index.
    assign w_reqIndex = address_in[IDX_HI:BL_OFFSET_W];

`ifdef MEM_RESP_ERR_EN
    // A request is in error when it is not block aligned or names a block
    // outside the array.
    assign w_reqErr = (|address_in[BL_OFFSET_W-1:0]) | (|address_in[ADDR_W-1:IDX_HI+1]);
`else
    logic w_unusedAddrBits;

    // Without error reporting the offset and upper bits carry no meaning.
    assign w_reqErr         = 1'b0;
    assign w_unusedAddrBits = ^{address_in[ADDR_W-1:IDX_HI+1], address_in[BL_OFFSET_W-1:0]};
`endif

    // The last WAIT edge is exactly LATENCY edges after acceptance because
    // the counter starts at 0 on the accept edge.
    assign w_lastCycle = (r_latCount == CNT_W'(LATENCY - 1));

    // The array reads every edge. While IDLE it is pointed at the incoming
    // request so that even LATENCY=1 has read data ready on the final edge;
    // afterwards it stays on the latched index.
    assign w_arrAddr = (r_state == IDLE) ? w_reqIndex : r_addr;
    assign w_arrWe   = (r_state == WAIT) && w_lastCycle && (r_op == WRITE) && !r_err;

    block_mem_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BLOCK_W    (BLOCK_W)
    ) u_array (
        .i_clk   (clk),
        .i_we    (w_arrWe),
        .i_addr  (w_arrAddr),
        .i_wdata (r_wdata),
        .o_rdata (w_arrRdata)
    );

    // Handshake FSM with all outputs registered. Requests are latched on
    // acceptance and inputs are ignored until the completion handshake; the
    // ACK_LOW state keeps a still-high store_req from being re-accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_op            <= READ;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_latCount      <= '0;
            r_err           <= 1'b0;
            data_out        <= '0;
            load_completed  <= 1'b0;
            store_completed <= 1'b0;
            busy            <= 1'b0;
`ifdef MEM_RESP_ERR_EN
            addr_err        <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (store_req) begin
                        r_op       <= WRITE;
                        r_addr     <= w_reqIndex;
                        r_wdata    <= data_in;
                        r_err      <= w_reqErr;
                        r_latCount <= '0;
                        busy       <= 1'b1;
                        r_state    <= WAIT;
                    end else if (load_req) begin
                        r_op       <= READ;
                        r_addr     <= w_reqIndex;
                        r_err      <= w_reqErr;
                        r_latCount <= '0;
                        busy       <= 1'b1;
                        r_state    <= WAIT;
                    end
                end

                WAIT: begin
                    if (w_lastCycle) begin
`ifdef MEM_RESP_ERR_EN
                        addr_err <= r_err;
`endif
                        if (r_op == WRITE) begin
                            store_completed <= 1'b1;
                            r_state         <= STORE_DONE;
                        end else begin
                            data_out       <= r_err ? '0 : w_arrRdata;
                            load_completed <= 1'b1;
                            r_state        <= LOAD_DONE;
                        end
                    end else begin
                        r_latCount <= r_latCount + CNT_W'(1);
                    end
                end

                LOAD_DONE: begin
                    if (!load_req) begin
                        load_completed <= 1'b0;
`ifdef MEM_RESP_ERR_EN
                        addr_err       <= 1'b0;
`endif
                        busy           <= 1'b0;
                        r_state        <= IDLE;
                    end
                end

                STORE_DONE: begin
                    if (store_ack) begin
                        store_completed <= 1'b0;
`ifdef MEM_RESP_ERR_EN
                        addr_err        <= 1'b0;
`endif
                        r_state         <= ACK_LOW;
                    end
                end

                ACK_LOW: begin
                    if (!store_ack && !store_req) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_block_mem_responder
// Self-checking bench for block_mem_responder: a constant vector table, hand
// sequences for the multi-cycle corner cases and randomized traffic checked
// against a plain array model of block storage.
// Optional feature macro: MEM_RESP_ERR_EN
// ---------------------------------------------------------------------------
module tb_block_mem_responder;

    localparam int LATENCY = 3;
    localparam int LIM     = 20;
`ifdef MEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        bit          isStore;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] expData;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] address_in;
    logic [31:0] data_in;
    logic        load_req;
    logic        store_req;
    logic        store_ack;
    logic [31:0] data_out;
    logic        load_completed;
    logic        store_completed;
    logic        busy;
`ifdef MEM_RESP_ERR_EN
    logic        addr_err;
`endif

    int checks = 0;
    int fails  = 0;

    logic [31:0] refMem   [256];
    bit          refValid [256];
    vec_t        vecs     [9];

    block_mem_responder #(
        .LATENCY (LATENCY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .address_in      (address_in),
        .data_in         (data_in),
        .load_req        (load_req),
        .store_req       (store_req),
        .store_ack       (store_ack),
        .data_out        (data_out),
        .load_completed  (load_completed),
        .store_completed (store_completed),
`ifdef MEM_RESP_ERR_EN
        .addr_err        (addr_err),
`endif
        .busy            (busy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refIndex(input logic [15:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic bit refErr(input logic [15:0] a);
        return ERR_EN && ((a[1:0] != 2'b00) || (a[15:10] != 6'b0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkErr(input string name, input bit expErr);
`ifdef MEM_RESP_ERR_EN
        checkOutput(name, addr_err, expErr);
`else
        if (expErr) $display("[TB] unexpected error expectation for %s", name);
`endif
    endtask

    task automatic waitCompletion(input bit isLoad, output int n);
        n = 0;
        while (((isLoad ? load_completed : store_completed) !== 1'b1) && n < LIM) begin
            tick();
            n++;
        end
    endtask

    // Full store transaction including the ack handshake; updates the model.
    task automatic doStore(input logic [15:0] a, input logic [31:0] d, input int hold, input bit dropEarly);
        int n;
        bit e;
        e          = refErr(a);
        address_in = a;
        data_in    = d;
        store_req  = 1'b1;
        tick();
        checkOutput("storeAcceptBusy", busy, 1);
        address_in = ~a;
        data_in    = ~d;
        if (dropEarly) store_req = 1'b0;
        waitCompletion(1'b0, n);
        checkOutput("storeLatency", n, LATENCY);
        checkOutput("storeNoLoad", load_completed, 0);
        checkErr("storeAddrErr", e);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput("storeHold", store_completed, 1);
        end
        store_ack = 1'b1;
        tick();
        checkOutput("storeAckFall", store_completed, 0);
        checkOutput("ackLowBusy", busy, 1);
        checkErr("storeErrClear", 1'b0);
        store_ack = 1'b0;
        store_req = 1'b0;
        tick();
        checkOutput("storeIdleBusy", busy, 0);
        if (!e) begin
            refMem[refIndex(a)]   = d;
            refValid[refIndex(a)] = 1'b1;
        end
    endtask

    // Full load transaction; expected data is forced to 0 for erroring loads.
    task automatic doLoad(input logic [15:0] a, input bit checkData, input logic [31:0] expData,
                          input int hold, input bit dropEarly);
        int n;
        bit e;
        logic [31:0] expOut;
        e          = refErr(a);
        expOut     = e ? 32'h0 : expData;
        address_in = a;
        load_req   = 1'b1;
        tick();
        checkOutput("loadAcceptBusy", busy, 1);
        address_in = ~a;
        if (dropEarly) load_req = 1'b0;
        waitCompletion(1'b1, n);
        checkOutput("loadLatency", n, LATENCY);
        if (checkData) checkOutput("loadData", data_out, expOut);
        checkErr("loadAddrErr", e);
        if (!dropEarly) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                checkOutput("loadHold", load_completed, 1);
                if (checkData) checkOutput("loadHoldData", data_out, expOut);
            end
        end
        load_req = 1'b0;
        tick();
        checkOutput("loadFall", load_completed, 0);
        checkOutput("loadIdleBusy", busy, 0);
        checkErr("loadErrClear", 1'b0);
        if (checkData) checkOutput("loadDataKept", data_out, expOut);
    endtask

    task automatic applyStimulus(input vec_t v, input int hold);
        if (v.isStore) doStore(v.addr, v.data, hold, 1'b0);
        else           doLoad(v.addr, 1'b1, v.expData, hold, 1'b0);
    endtask

    // Main sequence: reset, vector table, corner cases, random traffic.
    initial begin
        int n;

        vecs[0] = '{1'b1, 16'h0008, 32'h0000DEAD, 32'h0};
        vecs[1] = '{1'b0, 16'h0008, 32'h0,        32'h0000DEAD};
        vecs[2] = '{1'b1, 16'h03FC, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 16'h03FC, 32'h0,        32'h12345678};
        vecs[4] = '{1'b1, 16'h0000, 32'hA5A5A5A5, 32'h0};
        vecs[5] = '{1'b0, 16'h0000, 32'h0,        32'hA5A5A5A5};
        vecs[6] = '{1'b0, 16'h0008, 32'h0,        32'h0000DEAD};
        vecs[7] = '{1'b1, 16'h0008, 32'hFFFFFFFF, 32'h0};
        vecs[8] = '{1'b0, 16'h0008, 32'h0,        32'hFFFFFFFF};

        rst        = 1'b1;
        address_in = '0;
        data_in    = '0;
        load_req   = 1'b0;
        store_req  = 1'b0;
        store_ack  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetDataOut", data_out, 0);
        checkOutput("resetLoadDone", load_completed, 0);
        checkOutput("resetStoreDone", store_completed, 0);
        checkOutput("resetBusy", busy, 0);
        checkErr("resetAddrErr", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("idleBusy", busy, 0);

        $display("[TB] vector table");
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i % 3);

        $display("[TB] requests dropped before completion");
        doLoad(16'h0008, 1'b1, 32'hFFFFFFFF, 0, 1'b1);
        doStore(16'h0050, 32'h13572468, 0, 1'b1);
        doLoad(16'h0050, 1'b1, 32'h13572468, 1, 1'b0);

        $display("[TB] simultaneous store and load");
        address_in = 16'h0040;
        data_in    = 32'h0F0F1234;
        store_req  = 1'b1;
        load_req   = 1'b1;
        tick();
        waitCompletion(1'b0, n);
        checkOutput("bothStoreLatency", n, LATENCY);
        checkOutput("bothNoLoadYet", load_completed, 0);
        store_ack = 1'b1;
        tick();
        store_ack = 1'b0;
        store_req = 1'b0;
        tick();
        checkOutput("bothIdleBetween", busy, 0);
        tick();
        checkOutput("bothLoadAccepted", busy, 1);
        waitCompletion(1'b1, n);
        checkOutput("bothLoadLatency", n, LATENCY);
        checkOutput("bothLoadData", data_out, 32'h0F0F1234);
        load_req = 1'b0;
        tick();
        checkOutput("bothLoadFall", load_completed, 0);
        refMem[16]   = 32'h0F0F1234;
        refValid[16] = 1'b1;

        $display("[TB] reset during store wait");
        doStore(16'h0010, 32'h11223344, 0, 1'b0);
        address_in = 16'h0010;
        data_in    = 32'h55667788;
        store_req  = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetStoreDone", store_completed, 0);
        checkOutput("midResetLoadDone", load_completed, 0);
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetDataOut", data_out, 0);
        store_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
        doLoad(16'h0010, 1'b1, 32'h11223344, 0, 1'b0);

        $display("[TB] ack and request held high");
        address_in = 16'h0030;
        data_in    = 32'h5A5A0000;
        store_req  = 1'b1;
        tick();
        waitCompletion(1'b0, n);
        checkOutput("heldStoreLatency", n, LATENCY);
        store_ack = 1'b1;
        tick();
        checkOutput("heldAckFall", store_completed, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("heldBothBusy", busy, 1);
            checkOutput("heldBothNoDone", store_completed, 0);
        end
        store_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("heldReqBusy", busy, 1);
        end
        store_req = 1'b0;
        tick();
        checkOutput("heldReleaseIdle", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("heldNoReaccept", busy, 0);
            checkOutput("heldNoDone", store_completed, 0);
        end
        refMem[12]   = 32'h5A5A0000;
        refValid[12] = 1'b1;

`ifdef MEM_RESP_ERR_EN
        $display("[TB] address error handling");
        doStore(16'h0004, 32'h11112222, 0, 1'b0);
        doStore(16'h0006, 32'h0BAD0BAD, 0, 1'b0);
        doLoad(16'h0004, 1'b1, 32'h11112222, 0, 1'b0);
        doLoad(16'h8004, 1'b1, 32'h11112222, 0, 1'b0);
`else
        $display("[TB] index wrap and ignored offset bits");
        doStore(16'h0408, 32'hCAFEF00D, 0, 1'b0);
        doLoad(16'h0008, 1'b1, 32'hCAFEF00D, 0, 1'b0);
        doStore(16'h0017, 32'h0BADBEEF, 0, 1'b0);
        doLoad(16'hFC14, 1'b1, 32'h0BADBEEF, 0, 1'b0);
`endif

        $display("[TB] randomized traffic");
        for (int k = 0; k < 60; k++) begin
            logic [15:0] a;
            logic [5:0]  up;
            logic [7:0]  idx;
            logic [1:0]  lo;
            logic [31:0] d;
            int          hold;
            bit          drop;
            idx  = 8'(100 + $urandom_range(0, 7));
            up   = 6'($urandom_range(0, 63));
            lo   = 2'($urandom_range(0, 3));
            if (ERR_EN && $urandom_range(0, 3) != 0) begin
                up = '0;
                lo = '0;
            end
            a    = {up, idx, lo};
            d    = $urandom;
            hold = $urandom_range(0, 2);
            drop = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                doStore(a, d, hold, drop);
            end else begin
                doLoad(a, refValid[refIndex(a)] || refErr(a), refMem[refIndex(a)], hold, drop);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
